uc_mc_wait: RTL and testbench

- Parametrised successor to the multicycle control unit (UC) that drives the existing datapath: PC, IR, MDR, A/B, ALUOut, Banco_reg, Ula32 and the PC-source mux.
- Adds variable-latency memory support through a request/ready handshake with a bounded wait counter.
- Adds bne, addi and j decoding, and precise exceptions (opcode invalid, ALU overflow, memory timeout) that save the faulting PC into an EPC register and redirect to a fixed vector.

---
 rtl/uc_mc_wait_pkg.sv | 74 +++++++
 rtl/uc_mc_wait_if.sv | 15 +
 rtl/uc_mc_wait_mem_wait_ctr.sv | 39 +++
 rtl/uc_mc_wait.sv | 262 ++++++++++++++++++++++++++
 tb/tb_uc_mc_wait.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uc_mc_wait_pkg.sv
// uc_mc_pkg: shared types and encodings for the multicycle control unit.
//   state_t      - FSM state encoding (also exported on the State debug port)
//   OP_* / FN_*  - instruction opcode and R-type funct fields
//   ALU_*        - Ula32 operation selector codes
//   PCS_*        - PC-source mux selections
//   EXC_*        - exception cause codes
package uc_mc_pkg;

  typedef enum logic [3:0] {
    RST     = 4'd0,
    FETCH   = 4'd1,
    DECODE  = 4'd2,
    EXEC_R  = 4'd3,
    RWB     = 4'd4,
    EXEC_I  = 4'd5,
    IWB     = 4'd6,
    MEMADDR = 4'd7,
    MEMRD   = 4'd8,
    MEMWR   = 4'd9,
    LWB     = 4'd10,
    BRANCH  = 4'd11,
    JUMP    = 4'd12,
    EXC     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_XOR = 6'b100110;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_CMP  = 3'b111;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  localparam logic [1:0] PCS_EXC    = 2'b11;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_OPCODE  = 2'b01;
  localparam logic [1:0] EXC_OVF     = 2'b10;
  localparam logic [1:0] EXC_TIMEOUT = 2'b11;

  // Map an R-type funct to its Ula32 selector; ALU_NONE marks an unsupported funct.
  function automatic logic [2:0] funct_aluop(input logic [5:0] fn);
    logic [2:0] op;
    case (fn)
      FN_ADD:  op = ALU_ADD;
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_XOR:  op = ALU_XOR;
      default: op = ALU_NONE;
    endcase
    return op;
  endfunction

  // States that hold a memory request open and run the wait counter.
  function automatic logic is_wait_state(input state_t s);
    return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
  endfunction

endpackage

// File: rtl/uc_mc_wait_if.sv
// uc_mc_wait_if: memory request/ready handshake between the control unit
// (master) and the memory subsystem (slave).
//   MemReq   - request valid
//   MemWrite - request is a write
//   IorD     - address select: 0 = PC, 1 = ALUOut
//   MemReady - memory completed the current request
interface uc_mc_wait_if;
  logic MemReq;
  logic MemWrite;
  logic IorD;
  logic MemReady;

  modport master (output MemReq, output MemWrite, output IorD, input MemReady);
  modport slave  (input MemReq, input MemWrite, input IorD, output MemReady);
endinterface

// File: rtl/uc_mc_wait_mem_wait_ctr.sv
// mem_wait_ctr: counts cycles spent waiting for a memory response.
//   i_clk/i_rst - clock, synchronous active-high reset
//   i_clr       - clear (state change)
//   i_en        - count this cycle (waiting and no ready)
//   o_hit       - this is the MAX-th waiting cycle; a missing ready now times out
// The count saturates at MAX so it can wait indefinitely when timeouts are off.
module mem_wait_ctr #(
  parameter int MAX = 15
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);

  localparam int CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MAX);
  localparam logic [CW-1:0] LAST  = CW'(MAX - 1);

  logic [CW-1:0] r_cnt;

  // Wait-cycle counter with clear and saturation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Count already holds MAX-1 completed waits, so this cycle is the last allowed.
  assign o_hit = (r_cnt >= LAST);

endmodule

// File: rtl/uc_mc_wait.sv
// uc_mc_wait: multicycle control unit with variable-latency memory and
// precise exceptions.
//   Clk, Reset          - clock, synchronous active-high reset
//   Op, Funct           - IR[31:26], IR[5:0]
//   Zero, Overflow      - Ula32 flags
//   mem                 - memory handshake (MemReq/MemWrite/IorD out, MemReady in)
//   IRWrite..RegWrite   - datapath strobes and mux selects
//   ExcVector           - exception vector constant
//   ExcCause            - last exception cause (registered)
//   State               - current FSM state (debug)
module uc_mc_wait
  import uc_mc_pkg::*;
#(
  parameter int          MEM_WAIT_MAX = 15,
  parameter int          EXC_EN       = 1,
  parameter logic [31:0] EXC_VEC      = 32'h0000_00FF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [5:0]   Op,
  input  logic [5:0]   Funct,
  input  logic         Zero,
  input  logic         Overflow,
  uc_mc_wait_if.master mem,
  output logic         IRWrite,
  output logic         MDRLoad,
  output logic         ABLoad,
  output logic         ALUOutLoad,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [2:0]   ALUOp,
  output logic [1:0]   PCSource,
  output logic         PCWrite,
  output logic         EPCWrite,
  output logic         MemtoReg,
  output logic         RegDst,
  output logic         RegWrite,
  output logic [31:0]  ExcVector,
  output logic [1:0]   ExcCause,
  output logic [3:0]   State
);

  localparam logic EXC_ON = (EXC_EN != 0);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_cause;
  logic [1:0] w_cause;
  logic       w_hit;
  logic       w_wait;
  logic [2:0] w_fn_aluop;
  logic       w_fn_arith;
  logic       w_mem_req;
  logic       w_mem_write;
  logic       w_iord;

  assign w_fn_aluop = funct_aluop(Funct);
  assign w_fn_arith = (Funct == FN_ADD) || (Funct == FN_SUB);
  assign w_wait     = is_wait_state(r_state) && !mem.MemReady;

  mem_wait_ctr #(.MAX(MEM_WAIT_MAX)) u_ctr (
    .i_clk (Clk),
    .i_rst (Reset),
    .i_clr (w_next != r_state),
    .i_en  (w_wait),
    .o_hit (w_hit)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= RST;
    end else begin
      r_state <= w_next;
    end
  end

  // Exception cause: captured on entry to EXC, held until the next exception.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_cause <= EXC_NONE;
    end else if (w_next == EXC) begin
      r_cause <= w_cause;
    end else begin
      r_cause <= r_cause;
    end
  end

  // Next-state logic and the cause that goes with a transition into EXC.
  always_comb begin
    w_next  = r_state;
    w_cause = EXC_NONE;
    case (r_state)
      RST: w_next = FETCH;
      FETCH, MEMRD, MEMWR: begin
        // A ready arriving on the limit cycle takes priority over the timeout.
        if (mem.MemReady) begin
          case (r_state)
            FETCH:   w_next = DECODE;
            MEMRD:   w_next = LWB;
            default: w_next = FETCH;
          endcase
        end else if (EXC_ON && w_hit) begin
          w_next  = EXC;
          w_cause = EXC_TIMEOUT;
        end else begin
          w_next = r_state;
        end
      end
      DECODE: begin
        case (Op)
          OP_RTYPE:      w_next = EXEC_R;
          OP_LW, OP_SW:  w_next = MEMADDR;
          OP_BEQ, OP_BNE: w_next = BRANCH;
          OP_ADDI:       w_next = EXEC_I;
          OP_J:          w_next = JUMP;
          default: begin
            if (EXC_ON) begin
              w_next  = EXC;
              w_cause = EXC_OPCODE;
            end else begin
              w_next = FETCH;
            end
          end
        endcase
      end
      EXEC_R: begin
        if (w_fn_aluop == ALU_NONE) begin
          if (EXC_ON) begin
            w_next  = EXC;
            w_cause = EXC_OPCODE;
          end else begin
            w_next = FETCH;
          end
        end else if (EXC_ON && Overflow && w_fn_arith) begin
          w_next  = EXC;
          w_cause = EXC_OVF;
        end else begin
          w_next = RWB;
        end
      end
      EXEC_I: begin
        if (EXC_ON && Overflow) begin
          w_next  = EXC;
          w_cause = EXC_OVF;
        end else begin
          w_next = IWB;
        end
      end
      MEMADDR: begin
        if (Op == OP_LW) begin
          w_next = MEMRD;
        end else begin
          w_next = MEMWR;
        end
      end
      RWB, IWB, LWB, BRANCH, JUMP, EXC: w_next = FETCH;
      default: w_next = RST;
    endcase
  end

  // Control decode: a function of the state, plus MemReady on wait-state
  // completion and Zero for the branch decision.
  always_comb begin
    IRWrite     = 1'b0;
    MDRLoad     = 1'b0;
    ABLoad      = 1'b0;
    ALUOutLoad  = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = ALU_NONE;
    PCSource    = PCS_ALU;
    PCWrite     = 1'b0;
    EPCWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    w_mem_req   = 1'b0;
    w_mem_write = 1'b0;
    w_iord      = 1'b0;
    case (r_state)
      FETCH: begin
        w_mem_req = 1'b1;
        if (mem.MemReady) begin
          IRWrite = 1'b1;
          ALUSrcB = 2'b01;
          ALUOp   = ALU_ADD;
          PCWrite = 1'b1;
        end else begin
          IRWrite = 1'b0;
        end
      end
      DECODE: begin
        // Precompute the branch target into ALUOut while A/B load.
        ABLoad     = 1'b1;
        ALUSrcB    = 2'b11;
        ALUOp      = ALU_ADD;
        ALUOutLoad = 1'b1;
      end
      EXEC_R: begin
        ALUSrcA    = 1'b1;
        ALUOp      = w_fn_aluop;
        ALUOutLoad = 1'b1;
      end
      EXEC_I, MEMADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUOp      = ALU_ADD;
        ALUOutLoad = 1'b1;
      end
      MEMRD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
        MDRLoad   = mem.MemReady;
      end
      MEMWR: begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_iord      = 1'b1;
      end
      LWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      IWB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        PCSource = PCS_ALUOUT;
        if (Op == OP_BNE) begin
          PCWrite = !Zero;
        end else begin
          PCWrite = Zero;
        end
      end
      JUMP: begin
        PCSource = PCS_JUMP;
        PCWrite  = 1'b1;
      end
      EXC: begin
        EPCWrite = 1'b1;
        PCSource = PCS_EXC;
        PCWrite  = 1'b1;
      end
      default: begin
        PCWrite = 1'b0;
      end
    endcase
  end

  assign mem.MemReq   = w_mem_req;
  assign mem.MemWrite = w_mem_write;
  assign mem.IorD     = w_iord;
  assign ExcVector    = EXC_VEC;
  assign ExcCause     = r_cause;
  assign State        = r_state;

endmodule

// File: tb/tb_uc_mc_wait.sv
// Scoreboard bench for uc_mc_wait: each stimulus step pushes the expected
// {State, strobes, PCSource, ExcCause} tuple, which is popped and compared
// once the DUT outputs settle for that cycle.
module tb_uc_mc_wait;
  import uc_mc_pkg::*;

  // Strobe bit positions in the expected tuple.
  localparam logic [8:0] FL_0    = 9'h000;
  localparam logic [8:0] FL_MRQ  = 9'h100;
  localparam logic [8:0] FL_MWR  = 9'h080;
  localparam logic [8:0] FL_IORD = 9'h040;
  localparam logic [8:0] FL_IRW  = 9'h020;
  localparam logic [8:0] FL_MDR  = 9'h010;
  localparam logic [8:0] FL_RW   = 9'h008;
  localparam logic [8:0] FL_RDST = 9'h004;
  localparam logic [8:0] FL_PCW  = 9'h002;
  localparam logic [8:0] FL_EPC  = 9'h001;

  typedef struct packed {
    logic       rst;
    logic       rdy;
    logic       zero;
    logic       ovf;
    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] st;
    logic [8:0] fl;
    logic [1:0] pcs;
    logic [1:0] cause;
  } vec_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [5:0]  Op = 6'b000000;
  logic [5:0]  Funct = 6'b000000;
  logic        Zero = 1'b0;
  logic        Overflow = 1'b0;
  logic        IRWrite, MDRLoad, ABLoad, ALUOutLoad, ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUOp;
  logic [1:0]  PCSource;
  logic        PCWrite, EPCWrite, MemtoReg, RegDst, RegWrite;
  logic [31:0] ExcVector;
  logic [1:0]  ExcCause;
  logic [3:0]  State;

  uc_mc_wait_if mem_if ();

  uc_mc_wait #(.MEM_WAIT_MAX(15), .EXC_EN(1), .EXC_VEC(32'h0000_00FF)) dut (
    .Clk(Clk), .Reset(Reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .Overflow(Overflow), .mem(mem_if), .IRWrite(IRWrite), .MDRLoad(MDRLoad),
    .ABLoad(ABLoad), .ALUOutLoad(ALUOutLoad), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .PCWrite(PCWrite),
    .EPCWrite(EPCWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ExcVector(ExcVector), .ExcCause(ExcCause),
    .State(State)
  );

  always #5 Clk = ~Clk;

  logic [16:0] obs;
  assign obs = {State, mem_if.MemReq, mem_if.MemWrite, mem_if.IorD, IRWrite,
                MDRLoad, RegWrite, RegDst, PCWrite, EPCWrite, PCSource, ExcCause};

  logic [16:0] exp_q[$];
  logic [16:0] exp_v;
  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t V(input logic rst, rdy, zero, ovf,
                             input logic [5:0] op, fn, input logic [3:0] st,
                             input logic [8:0] fl, input logic [1:0] pcs, cause);
    vec_t v;
    v = {rst, rdy, zero, ovf, op, fn, st, fl, pcs, cause};
    return v;
  endfunction

  // Drive one cycle of stimulus mid-period and queue its expectation.
  task automatic apply(input vec_t v);
    @(negedge Clk);
    Reset = v.rst;
    mem_if.MemReady = v.rdy;
    Zero = v.zero;
    Overflow = v.ovf;
    Op = v.op;
    Funct = v.fn;
    exp_q.push_back({v.st, v.fl, v.pcs, v.cause});
    #1;
  endtask

  task automatic test_reset();
    vec_t t[$];
    t.push_back(V(1'b1, 1'b0, 1'b0, 1'b0, OP_RTYPE, FN_ADD, RST, FL_0, 2'b00, 2'b00));
    t.push_back(V(1'b1, 1'b1, 1'b0, 1'b0, OP_RTYPE, FN_ADD, RST, FL_0, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_RTYPE, FN_ADD, RST, FL_0, 2'b00, 2'b00));
    foreach (t[i]) begin
      apply(t[i]);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL reset step %0d: got %h want %h", i, obs, exp_v);
      end
      n_vec++;
      if ({ALUSrcB, ALUOp, ExcVector} !== {2'b00, 3'b000, 32'h0000_00FF}) begin
        n_err++;
        $display("FAIL reset_sel step %0d: got %b/%b/%h want 00/000/000000ff", i, ALUSrcB, ALUOp, ExcVector);
      end
    end
  endtask

  task automatic test_add();
    vec_t t[$];
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_RTYPE, FN_ADD, FETCH, FL_MRQ | FL_IRW | FL_PCW, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_RTYPE, FN_ADD, DECODE, FL_0, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_RTYPE, FN_ADD, EXEC_R, FL_0, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_RTYPE, FN_ADD, RWB, FL_RW | FL_RDST, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_RTYPE, FN_SUB, FETCH, FL_MRQ | FL_IRW | FL_PCW, 2'b00, 2'b00));
    foreach (t[i]) begin
      apply(t[i]);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL add step %0d: got %h want %h", i, obs, exp_v);
      end
      if (t[i].st == EXEC_R) begin
        n_vec++;
        if ({ALUSrcA, ALUSrcB, ALUOp} !== {1'b1, 2'b00, 3'b001}) begin
          n_err++;
          $display("FAIL add_alu: got %b/%b/%b want 1/00/001", ALUSrcA, ALUSrcB, ALUOp);
        end
      end
    end
    // Finish the sub so the next test starts in FETCH.
    t.delete();
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_RTYPE, FN_SUB, DECODE, FL_0, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_RTYPE, FN_SUB, EXEC_R, FL_0, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_RTYPE, FN_SUB, RWB, FL_RW | FL_RDST, 2'b00, 2'b00));
    foreach (t[i]) begin
      apply(t[i]);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL sub step %0d: got %h want %h", i, obs, exp_v);
      end
      if (t[i].st == EXEC_R) begin
        n_vec++;
        if (ALUOp !== 3'b010) begin
          n_err++;
          $display("FAIL sub_alu: got %b want 010", ALUOp);
        end
      end
    end
  endtask

  task automatic test_lw_wait();
    vec_t t[$];
    for (int k = 0; k < 3; k++)
      t.push_back(V(1'b0, 1'b0, 1'b0, 1'b0, OP_LW, 6'b000000, FETCH, FL_MRQ, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_LW, 6'b000000, FETCH, FL_MRQ | FL_IRW | FL_PCW, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_LW, 6'b000000, DECODE, FL_0, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b0, 1'b0, 1'b0, OP_LW, 6'b000000, MEMADDR, FL_0, 2'b00, 2'b00));
    for (int k = 0; k < 3; k++)
      t.push_back(V(1'b0, 1'b0, 1'b0, 1'b0, OP_LW, 6'b000000, MEMRD, FL_MRQ | FL_IORD, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_LW, 6'b000000, MEMRD, FL_MRQ | FL_IORD | FL_MDR, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b0, 1'b0, 1'b0, OP_LW, 6'b000000, LWB, FL_RW, 2'b00, 2'b00));
    foreach (t[i]) begin
      apply(t[i]);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL lw_wait step %0d: got %h want %h", i, obs, exp_v);
      end
      if (t[i].st == LWB) begin
        n_vec++;
        if ({MemtoReg, RegDst} !== 2'b10) begin
          n_err++;
          $display("FAIL lwb_sel: got %b want 10", {MemtoReg, RegDst});
        end
      end
    end
  endtask

  task automatic test_branch();
    vec_t t[$];
    logic [5:0] ops[3] = '{OP_BEQ, OP_BNE, OP_BNE};
    logic       zs[3]  = '{1'b1, 1'b1, 1'b0};
    logic [8:0] pw[3]  = '{FL_PCW, FL_0, FL_PCW};
    for (int k = 0; k < 3; k++) begin
      t.push_back(V(1'b0, 1'b1, zs[k], 1'b0, ops[k], 6'b000000, FETCH, FL_MRQ | FL_IRW | FL_PCW, 2'b00, 2'b00));
      t.push_back(V(1'b0, 1'b1, zs[k], 1'b0, ops[k], 6'b000000, DECODE, FL_0, 2'b00, 2'b00));
      t.push_back(V(1'b0, 1'b1, zs[k], 1'b0, ops[k], 6'b000000, BRANCH, pw[k], 2'b01, 2'b00));
    end
    foreach (t[i]) begin
      apply(t[i]);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL branch step %0d: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_addi_ovf();
    vec_t t[$];
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_ADDI, 6'b000000, FETCH, FL_MRQ | FL_IRW | FL_PCW, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_ADDI, 6'b000000, DECODE, FL_0, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_ADDI, 6'b000000, EXEC_I, FL_0, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_ADDI, 6'b000000, IWB, FL_RW, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_ADDI, 6'b000000, FETCH, FL_MRQ | FL_IRW | FL_PCW, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_ADDI, 6'b000000, DECODE, FL_0, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b1, OP_ADDI, 6'b000000, EXEC_I, FL_0, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_ADDI, 6'b000000, EXC, FL_EPC | FL_PCW, 2'b11, 2'b10));
    foreach (t[i]) begin
      apply(t[i]);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL addi_ovf step %0d: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_timeout();
    vec_t t[$];
    for (int k = 0; k < 15; k++)
      t.push_back(V(1'b0, 1'b0, 1'b0, 1'b0, OP_J, 6'b000000, FETCH, FL_MRQ, 2'b00, 2'b10));
    t.push_back(V(1'b0, 1'b0, 1'b0, 1'b0, OP_J, 6'b000000, EXC, FL_EPC | FL_PCW, 2'b11, 2'b11));
    for (int k = 0; k < 14; k++)
      t.push_back(V(1'b0, 1'b0, 1'b0, 1'b0, OP_J, 6'b000000, FETCH, FL_MRQ, 2'b00, 2'b11));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_J, 6'b000000, FETCH, FL_MRQ | FL_IRW | FL_PCW, 2'b00, 2'b11));
    t.push_back(V(1'b0, 1'b0, 1'b0, 1'b0, OP_J, 6'b000000, DECODE, FL_0, 2'b00, 2'b11));
    t.push_back(V(1'b0, 1'b0, 1'b0, 1'b0, OP_J, 6'b000000, JUMP, FL_PCW, 2'b10, 2'b11));
    foreach (t[i]) begin
      apply(t[i]);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL timeout step %0d: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_bad_op();
    vec_t t[$];
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, 6'b111111, 6'b000000, FETCH, FL_MRQ | FL_IRW | FL_PCW, 2'b00, 2'b11));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, 6'b111111, 6'b000000, DECODE, FL_0, 2'b00, 2'b11));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, 6'b111111, 6'b000000, EXC, FL_EPC | FL_PCW, 2'b11, 2'b01));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_RTYPE, 6'b111111, FETCH, FL_MRQ | FL_IRW | FL_PCW, 2'b00, 2'b01));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_RTYPE, 6'b111111, DECODE, FL_0, 2'b00, 2'b01));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_RTYPE, 6'b111111, EXEC_R, FL_0, 2'b00, 2'b01));
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_RTYPE, 6'b111111, EXC, FL_EPC | FL_PCW, 2'b11, 2'b01));
    foreach (t[i]) begin
      apply(t[i]);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL bad_op step %0d: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_memwr();
    vec_t t[$];
    t.push_back(V(1'b0, 1'b1, 1'b0, 1'b0, OP_SW, 6'b000000, FETCH, FL_MRQ | FL_IRW | FL_PCW, 2'b00, 2'b01));
    t.push_back(V(1'b0, 1'b0, 1'b0, 1'b0, OP_SW, 6'b000000, DECODE, FL_0, 2'b00, 2'b01));
    t.push_back(V(1'b0, 1'b0, 1'b0, 1'b0, OP_SW, 6'b000000, MEMADDR, FL_0, 2'b00, 2'b01));
    t.push_back(V(1'b0, 1'b0, 1'b0, 1'b0, OP_SW, 6'b000000, MEMWR, FL_MRQ | FL_MWR | FL_IORD, 2'b00, 2'b01));
    t.push_back(V(1'b1, 1'b0, 1'b0, 1'b0, OP_SW, 6'b000000, MEMWR, FL_MRQ | FL_MWR | FL_IORD, 2'b00, 2'b01));
    t.push_back(V(1'b1, 1'b0, 1'b0, 1'b0, OP_SW, 6'b000000, RST, FL_0, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b0, 1'b0, 1'b0, OP_SW, 6'b000000, RST, FL_0, 2'b00, 2'b00));
    t.push_back(V(1'b0, 1'b0, 1'b0, 1'b0, OP_SW, 6'b000000, FETCH, FL_MRQ, 2'b00, 2'b00));
    foreach (t[i]) begin
      apply(t[i]);
      exp_v = exp_q.pop_front();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL reset_memwr step %0d: got %h want %h", i, obs, exp_v);
      end
    end
  endtask

  initial begin
    mem_if.MemReady = 1'b0;
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_addi_ovf();
    test_timeout();
    test_bad_op();
    test_reset_mid_memwr();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
